mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates a single-port unified memory between the processor's instruction-fetch port and its load/store port. Each access runs as a multi-cycle transaction: arbitrate, issue, wait for memory ready (bounded by a timeout), respond. Sits between the PC/fetch logic and data-memory path on one side and the shared memory on the other. Its per-port done pulses are what stall and release the core.

## Interface

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 15, maximum WAIT cycles before abort; legal range 1..255

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk, state cleared when reset==0
- if_req  in  1  fetch request (level)
- if_addr  in  AW  fetch address
- if_done  out  1  fetch transaction complete, one-cycle pulse
- if_err  out  1  fetch timed out; valid only with if_done
- if_rdata  out  DW  fetch data; valid with if_done
- d_req  in  1  data request (level)
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_done  out  1  data transaction complete, one-cycle pulse
- d_err  out  1  data timed out; valid only with d_done
- d_rdata  out  DW  load data; valid with d_done
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  write enable; high only together with mem_en
- mem_addr  out  AW  latched access address
- mem_wdata  out  DW  latched store data
- mem_rdata  in  DW  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completion, one-cycle pulse
- busy  out  1  high in every state except IDLE

## Operation

- States are IDLE, ISSUE, WAIT and RESP. Transition rules:
  - IDLE → ISSUE when either request is high, otherwise stay.
  - ISSUE → WAIT always.
  - WAIT → RESP on mem_ready, or on timeout.
  - RESP → IDLE always.
- Requests are sampled only in IDLE. Requesters hold req, address and write data stable until their done pulse. They drop req on the edge after done, or keep it high to start a new transaction.
- Arbitration happens in IDLE:
  - Single request: grant that port.
  - Both requesting: grant the port not granted last (round-robin).
  - last_gnt resets to "fetch", so data wins the first tie.
  - last_gnt updates on every grant.
- On grant, latch the port select, address, we and wdata. A fetch grant forces we=0 and wdata=0.
- ISSUE: mem_en=1, mem_we=latched we, mem_addr/mem_wdata driven from the latches.
- WAIT: a timeout counter (8 bits) starts at 1 on the first WAIT cycle and increments each cycle.
  - mem_ready on any WAIT cycle, including cycle number TIMEOUT, completes the transaction successfully and captures mem_rdata.
  - If WAIT cycle TIMEOUT ends without mem_ready, the transaction aborts with err=1.
- RESP: exactly one of if_done/d_done pulses, for the granted port.
  - err is set on timeout only.
  - rdata = captured mem_rdata for a successful load or fetch.
  - rdata = 0 for stores and for timeouts.
- rdata outputs hold their value until the next done on the same port.
- mem_ready outside WAIT is ignored.

## Timing

- Reset values (reset==0):
  - State IDLE, last_gnt = fetch, counter 0.
  - All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, if_done, if_err, if_rdata, d_done, d_err, d_rdata, busy.
- Reset mid-transaction: abandon immediately.
  - No done pulse for the abandoned transaction.
  - mem_en=0 from the following cycle.
  - Requests are re-arbitrated fresh after reset is released.
- Minimum latency, with req seen in IDLE at cycle 0:
  - ISSUE (mem_en) at cycle 1.
  - mem_ready at cycle 2.
  - done at cycle 3.
  - Next IDLE at cycle 4.
  - Back-to-back throughput is therefore one access per 4 cycles.
- Each extra WAIT cycle adds one cycle of latency. A timeout gives done at cycle 2+TIMEOUT.
- mem_en is high exactly one cycle per transaction. It is never high while a previous transaction is in WAIT.
- busy is high in cycles 1..3 of the minimum case; IDLE has busy=0.

## Test plan

- Fetch only, reset released, if_req=1, if_addr=0x40, mem_ready one cycle after mem_en with mem_rdata=0xE3A00001 → mem_en at cycle 1 with mem_addr=0x40, mem_we=0; if_done at cycle 3 with if_rdata=0xE3A00001, if_err=0; d_done never pulses.
- Simultaneous if_req and d_req (d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF), both held → first grant goes to data (mem_we=1, mem_wdata=0xDEADBEEF, d_rdata=0), second grant to fetch, third to data; grants alternate for 6 transactions.
- Data load with mem_ready withheld, TIMEOUT=15 → d_done at cycle 17 with d_err=1, d_rdata=0. A mem_ready in a later IDLE is ignored.
- mem_ready on exactly WAIT cycle 15 (TIMEOUT=15) → successful completion, d_err=0, data captured.
- reset driven low during WAIT of a fetch → no if_done; all outputs 0 the next cycle; after release with if_req still high, a fresh transaction starts (mem_en 1 cycle after the first IDLE).
- Spurious mem_ready pulses in IDLE, ISSUE and RESP → no state change, no done, no rdata update.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch and data requester ports plus the shared memory bus
interface mem_port_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic          if_err;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_done;
    logic          d_err;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          busy;
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_done, if_err, if_rdata, d_done, d_err, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_done, if_err, if_rdata, d_done, d_err, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter giving fetch and load/store ports turns on one memory port
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t        state, nxt;
    logic          start, gnt_d, fin, sel, we, last, err;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, if_rd, d_rd;
    logic [7:0]    cnt;
    assign start = bus.if_req | bus.d_req;
    // last = 1 means data was granted last, so fetch wins the next tie
    assign gnt_d = bus.d_req & (~bus.if_req | ~last);
    always_ff @(posedge clk) state <= !reset ? IDLE : nxt;
    always_comb begin
        nxt           = state;
        fin           = 1'b0;
        case (state)
            IDLE:    nxt = start ? ISSUE : IDLE;
            ISSUE:   nxt = WAIT;
            WAIT: begin
                fin = bus.mem_ready | (cnt == 8'(TIMEOUT));
                nxt = fin ? RESP : WAIT;
            end
            default: nxt = IDLE;
        endcase
        bus.mem_en    = state == ISSUE;
        bus.mem_we    = state == ISSUE && we;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.busy      = state != IDLE;
        bus.if_done   = state == RESP && !sel;
        bus.d_done    = state == RESP && sel;
        bus.if_err    = state == RESP && !sel && err;
        bus.d_err     = state == RESP && sel && err;
        bus.if_rdata  = if_rd;
        bus.d_rdata   = d_rd;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            sel   <= 1'b0;
            we    <= 1'b0;
            last  <= 1'b0;
            err   <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            if_rd <= '0;
            d_rd  <= '0;
            cnt   <= '0;
        end else begin
            if (state == IDLE && start) begin
                sel   <= gnt_d;
                last  <= gnt_d;
                we    <= gnt_d & bus.d_we;
                addr  <= gnt_d ? bus.d_addr : bus.if_addr;
                wdata <= gnt_d ? bus.d_wdata : '0;
            end
            cnt <= state == ISSUE ? 8'd1 : state == WAIT ? cnt + 8'd1 : cnt;
            // fetches never write, so one rule covers both ports' read data
            if (fin) begin
                err <= !bus.mem_ready;
                if (sel)
                    d_rd <= bus.mem_ready && !we ? bus.mem_rdata : '0;
                else
                    if_rd <= bus.mem_ready && !we ? bus.mem_rdata : '0;
            end
        end
    end
endmodule
